// File: rtl/usb_fs_pkg.sv
// Shared definitions for the full-speed USB receive line decoder:
// line-state encodings, receiver state enum and framing constants.
package usb_fs_pkg;

    // Line state as {dp, dn} after synchronization.
    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_K   = 2'b01,
        LS_J   = 2'b10,
        LS_SE1 = 2'b11
    } line_state_t;

    typedef enum logic [1:0] {
        RX_IDLE     = 2'd0,
        RX_DATA     = 2'd1,
        RX_WAIT_EOP = 2'd2
    } rx_state_t;

    // Sync pattern as it appears in the shift register (newest bit at the MSB):
    // seven 0s followed by a 1.
    localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;

    // Number of consecutive 1s after which the transmitter inserts a 0.
    localparam logic [2:0] STUFF_LIMIT = 3'd6;

    // NRZI: no transition between samples means a 1.
    function automatic logic nrzi_decode(input line_state_t cur, input line_state_t prev);
        return (cur == prev);
    endfunction

endpackage

// File: rtl/usb_fs_rx_line_if.sv
// Signal bundle between the line mux / top level and the packet receiver.
// The decoder is the master: it consumes the line values and produces the
// framed byte stream.
interface usb_fs_rx_line_if;
    logic       rx_en;
    logic       dp_rx;
    logic       dn_rx;
    logic       pkt_start;
    logic [7:0] data;
    logic       data_valid;
    logic       pkt_end;
    logic       stuff_err;
    logic       eop_err;

    modport master (
        input  rx_en, dp_rx, dn_rx,
        output pkt_start, data, data_valid, pkt_end, stuff_err, eop_err
    );

    modport slave (
        output rx_en, dp_rx, dn_rx,
        input  pkt_start, data, data_valid, pkt_end, stuff_err, eop_err
    );
endinterface

// File: rtl/usb_fs_rx_dpll.sv
// Input synchronizer, line-state decode and 4x oversampling DPLL.
// Produces a one-clock sample strobe near the middle of each bit cell and
// the line state held for that bit.
module usb_fs_rx_dpll
    import usb_fs_pkg::*;
#(
    parameter int SYNC_STAGES = 2   // must be at least 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dp_rx_i,
    input  logic        dn_rx_i,
    output logic        strobe_o,
    output line_state_t sample_o
);

    logic [SYNC_STAGES-1:0] dp_sync_q;
    logic [SYNC_STAGES-1:0] dn_sync_q;
    line_state_t            raw_state;
    line_state_t            line_q, line_d;
    logic [1:0]             phase_q, phase_d;

    // Synchronizer chains; reset to the idle J level so no false SE0 appears.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dp_sync_q <= '1;
            dn_sync_q <= '0;
        end else begin
            dp_sync_q <= {dp_sync_q[SYNC_STAGES-2:0], dp_rx_i};
            dn_sync_q <= {dn_sync_q[SYNC_STAGES-2:0], dn_rx_i};
        end
    end

    // Decode line state (SE1 keeps the previous state) and realign the phase on any change.
    always_comb begin
        raw_state = line_state_t'({dp_sync_q[SYNC_STAGES-1], dn_sync_q[SYNC_STAGES-1]});
        line_d    = (raw_state == LS_SE1) ? line_q : raw_state;
        phase_d   = (line_d != line_q) ? 2'd0 : phase_q + 2'd1;
    end

    // Line state and free-running phase counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_q  <= LS_J;
            phase_q <= 2'd0;
        end else begin
            line_q  <= line_d;
            phase_q <= phase_d;
        end
    end

    // Phase 2 lands two clocks after the edge, i.e. mid-cell for 3..5 clock bits.
    assign strobe_o = (phase_q == 2'd2);
    assign sample_o = line_q;

endmodule

// File: rtl/usb_fs_rx_line.sv
// Full-speed USB receive line decoder: NRZI decode, sync detection,
// bit unstuffing, byte assembly and EOP detection on top of the DPLL.
module usb_fs_rx_line
    import usb_fs_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    usb_fs_rx_line_if.master rx_if
);

    // The sync shift register idles at all ones: an all-zero value would let a
    // single idle 1 look like a complete sync pattern.
    localparam logic [7:0] SHREG_IDLE = 8'hFF;

    logic        strobe;
    line_state_t sample;

    rx_state_t   state_q, state_d;
    line_state_t prev_q, prev_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  byte_q, byte_d;
    logic [7:0]  data_q, data_d;
    logic [2:0]  ones_q, ones_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic        se0_q, se0_d;
    logic        pkt_start_q, pkt_start_d;
    logic        data_valid_q, data_valid_d;
    logic        pkt_end_q, pkt_end_d;
    logic        stuff_err_q, stuff_err_d;
    logic        eop_err_q, eop_err_d;
    logic        dec_bit;
    logic [7:0]  shreg_shift;

    usb_fs_rx_dpll #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_dpll (
        .clk      (clk),
        .reset_n  (reset_n),
        .dp_rx_i  (rx_if.dp_rx),
        .dn_rx_i  (rx_if.dn_rx),
        .strobe_o (strobe),
        .sample_o (sample)
    );

    // Next-state logic: NRZI decode, sync search, unstuffing, byte assembly, EOP.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        shreg_d      = shreg_q;
        byte_d       = byte_q;
        data_d       = data_q;
        ones_d       = ones_q;
        bitcnt_d     = bitcnt_q;
        se0_d        = se0_q;
        pkt_start_d  = 1'b0;
        data_valid_d = 1'b0;
        pkt_end_d    = 1'b0;
        stuff_err_d  = 1'b0;
        eop_err_d    = 1'b0;
        dec_bit      = nrzi_decode(sample, prev_q);
        shreg_shift  = {dec_bit, shreg_q[7:1]};

        if (!rx_if.rx_en) begin
            // Receiver disabled (we are transmitting): abort any packet and park.
            if (state_q != RX_IDLE) begin
                pkt_end_d = 1'b1;
                eop_err_d = 1'b1;
            end
            state_d = RX_IDLE;
            prev_d  = LS_J;
            shreg_d = SHREG_IDLE;
            se0_d   = 1'b0;
        end else if (strobe) begin
            prev_d = sample;
            case (state_q)
                RX_IDLE: begin
                    if (sample == LS_SE0) begin
                        shreg_d = SHREG_IDLE;
                    end else if (shreg_shift == SYNC_PATTERN) begin
                        pkt_start_d = 1'b1;
                        state_d     = RX_DATA;
                        shreg_d     = SHREG_IDLE;
                        ones_d      = 3'd1;   // last sync bit is a 1
                        bitcnt_d    = 3'd0;
                        se0_d       = 1'b0;
                    end else begin
                        shreg_d = shreg_shift;
                    end
                end
                RX_DATA: begin
                    if (sample == LS_SE0) begin
                        se0_d = 1'b1;
                    end else if (se0_q && sample == LS_J) begin
                        pkt_end_d = 1'b1;
                        eop_err_d = (bitcnt_q != 3'd0);
                        state_d   = RX_IDLE;
                        se0_d     = 1'b0;
                    end else begin
                        se0_d = 1'b0;
                        if (ones_q == STUFF_LIMIT) begin
                            if (!dec_bit) begin
                                ones_d = 3'd0;        // stuffed 0, dropped
                            end else begin
                                stuff_err_d = 1'b1;
                                state_d     = RX_WAIT_EOP;
                            end
                        end else begin
                            byte_d   = {dec_bit, byte_q[7:1]};
                            ones_d   = dec_bit ? ones_q + 3'd1 : 3'd0;
                            bitcnt_d = bitcnt_q + 3'd1;   // wraps to 0 after the 8th bit
                            if (bitcnt_q == 3'd7) begin
                                data_d       = byte_d;
                                data_valid_d = 1'b1;
                            end
                        end
                    end
                end
                RX_WAIT_EOP: begin
                    if (sample == LS_SE0) begin
                        se0_d = 1'b1;
                    end else if (se0_q && sample == LS_J) begin
                        pkt_end_d = 1'b1;
                        state_d   = RX_IDLE;
                        se0_d     = 1'b0;
                    end else begin
                        se0_d = 1'b0;
                    end
                end
                default: begin
                    state_d = RX_IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered output flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RX_IDLE;
            prev_q       <= LS_J;
            shreg_q      <= SHREG_IDLE;
            byte_q       <= 8'h00;
            data_q       <= 8'h00;
            ones_q       <= 3'd0;
            bitcnt_q     <= 3'd0;
            se0_q        <= 1'b0;
            pkt_start_q  <= 1'b0;
            data_valid_q <= 1'b0;
            pkt_end_q    <= 1'b0;
            stuff_err_q  <= 1'b0;
            eop_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            shreg_q      <= shreg_d;
            byte_q       <= byte_d;
            data_q       <= data_d;
            ones_q       <= ones_d;
            bitcnt_q     <= bitcnt_d;
            se0_q        <= se0_d;
            pkt_start_q  <= pkt_start_d;
            data_valid_q <= data_valid_d;
            pkt_end_q    <= pkt_end_d;
            stuff_err_q  <= stuff_err_d;
            eop_err_q    <= eop_err_d;
        end
    end

    assign rx_if.pkt_start  = pkt_start_q;
    assign rx_if.data       = data_q;
    assign rx_if.data_valid = data_valid_q;
    assign rx_if.pkt_end    = pkt_end_q;
    assign rx_if.stuff_err  = stuff_err_q;
    assign rx_if.eop_err    = eop_err_q;

endmodule

// File: tb/tb_usb_fs_rx_line.sv
// Self-checking bench for usb_fs_rx_line: packets are built from bit lists,
// stuffed and NRZI-encoded on the wire; expectations come from the bit lists.
module tb_usb_fs_rx_line;
    import usb_fs_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #10 clk = ~clk;

    usb_fs_rx_line_if bus();

    usb_fs_rx_line #(.SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rx_if   (bus)
    );

    // Event log collected from the DUT outputs, sampled on the falling edge.
    int         n_start = 0, n_end = 0, n_eoperr = 0, n_stufferr = 0, n_bad = 0;
    logic [7:0] byte_log[$];

    always @(negedge clk) begin
        if (bus.pkt_start)  n_start    <= n_start + 1;
        if (bus.pkt_end)    n_end      <= n_end + 1;
        if (bus.eop_err)    n_eoperr   <= n_eoperr + 1;
        if (bus.stuff_err)  n_stufferr <= n_stufferr + 1;
        if (bus.data_valid) byte_log.push_back(bus.data);
        if ((bus.pkt_start && bus.data_valid) || (bus.data_valid && bus.pkt_end) ||
            (bus.eop_err && !bus.pkt_end))
            n_bad <= n_bad + 1;
    end

    int n_checks = 0, n_fail = 0;
    int s_start, s_end, s_eop, s_stuff, s_bytes;
    bit tx_bits[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] st, input int n);
        bus.dp_rx = st[1];
        bus.dn_rx = st[0];
        repeat (n) @(negedge clk);
    endtask

    task automatic add_byte(input logic [7:0] b);
        for (int j = 0; j < 8; j++) tx_bits.push_back(b[j]);
    endtask

    task automatic snap();
        s_start = n_start; s_end = n_end; s_eop = n_eoperr;
        s_stuff = n_stufferr; s_bytes = byte_log.size();
    endtask

    // Idle J, sync, tx_bits (optionally stuffed), optional EOP; NRZI on the wire.
    task automatic send(input bit do_stuff, input bit jit, input bit with_eop);
        bit          wb[$];
        int          ones;
        logic [1:0]  lvl;
        for (int i = 0; i < 7; i++) wb.push_back(1'b0);
        wb.push_back(1'b1);
        ones = 1;
        foreach (tx_bits[i]) begin
            wb.push_back(tx_bits[i]);
            ones = tx_bits[i] ? ones + 1 : 0;
            if (do_stuff && ones == 6) begin
                wb.push_back(1'b0);
                ones = 0;
            end
        end
        lvl = LS_J;
        drive(LS_J, 8);
        foreach (wb[i]) begin
            if (!wb[i]) lvl = (lvl == LS_J) ? LS_K : LS_J;
            drive(lvl, jit ? ((i % 2) ? 5 : 3) : 4);
        end
        if (with_eop) begin
            drive(LS_SE0, 8);
            drive(LS_J, 16);
        end
    endtask

    task automatic expect_pkt(input string tag, input int e_start, input int e_nb,
                              input int e_end, input int e_eop, input int e_stuff);
        int         nb;
        logic [7:0] eb;
        nb = byte_log.size() - s_bytes;
        $display("pkt %s: starts=%0d bytes=%0d ends=%0d eop_err=%0d stuff_err=%0d",
                 tag, n_start - s_start, nb, n_end - s_end, n_eoperr - s_eop, n_stufferr - s_stuff);
        chk({tag, " pkt_start"}, n_start - s_start, e_start);
        chk({tag, " byte count"}, nb, e_nb);
        chk({tag, " pkt_end"}, n_end - s_end, e_end);
        chk({tag, " eop_err"}, n_eoperr - s_eop, e_eop);
        chk({tag, " stuff_err"}, n_stufferr - s_stuff, e_stuff);
        for (int k = 0; k < e_nb && k < nb; k++) begin
            for (int j = 0; j < 8; j++) eb[j] = tx_bits[8*k + j];
            chk($sformatf("%s byte%0d", tag, k), byte_log[s_bytes + k], eb);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " pkt_start"}, bus.pkt_start, 0);
        chk({tag, " data"}, bus.data, 0);
        chk({tag, " data_valid"}, bus.data_valid, 0);
        chk({tag, " pkt_end"}, bus.pkt_end, 0);
        chk({tag, " stuff_err"}, bus.stuff_err, 0);
        chk({tag, " eop_err"}, bus.eop_err, 0);
    endtask

    initial begin
        int nb;
        bit jit;
        reset_n    = 1'b0;
        bus.rx_en  = 1'b1;
        bus.dp_rx  = 1'b1;
        bus.dn_rx  = 1'b0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        reset_n = 1'b1;
        drive(LS_J, 40);
        chk("idle no pkt_start", n_start, 0);

        // Clean packet
        tx_bits = {}; add_byte(8'hA5); add_byte(8'h3C);
        snap(); send(1, 0, 1); drive(LS_J, 4);
        expect_pkt("clean", 1, 2, 1, 0, 0);
        chk("data hold", bus.data, 8'h3C);

        // Bit stuffing
        tx_bits = {}; add_byte(8'hFF); add_byte(8'h00);
        snap(); send(1, 0, 1); drive(LS_J, 4);
        expect_pkt("stuffing", 1, 2, 1, 0, 0);

        // Stuff violation: seven 1s counting the last sync bit, no stuffing
        tx_bits = {};
        for (int i = 0; i < 7; i++) tx_bits.push_back(1'b1);
        for (int i = 0; i < 3; i++) tx_bits.push_back(1'b0);
        snap(); send(0, 0, 1); drive(LS_J, 4);
        expect_pkt("stuff_violation", 1, 0, 1, 0, 1);

        // Misaligned EOP after 12 random data bits
        tx_bits = {};
        for (int i = 0; i < 12; i++) tx_bits.push_back(1'($urandom_range(0, 1)));
        snap(); send(1, 0, 1); drive(LS_J, 4);
        expect_pkt("misaligned", 1, 1, 1, 1, 0);

        // Jitter: alternating 3/5 clock bit periods
        tx_bits = {}; add_byte(8'hA5);
        snap(); send(1, 1, 1); drive(LS_J, 4);
        expect_pkt("jitter", 1, 1, 1, 0, 0);

        // Random packets
        for (int r = 0; r < 6; r++) begin
            nb  = $urandom_range(1, 4);
            jit = 1'($urandom_range(0, 1));
            tx_bits = {};
            for (int b = 0; b < nb; b++) add_byte(8'($urandom));
            snap(); send(1, jit, 1); drive(LS_J, 4);
            expect_pkt($sformatf("random%0d", r), 1, nb, 1, 0, 0);
        end

        // rx_en dropped mid-byte
        tx_bits = {};
        for (int i = 0; i < 12; i++) tx_bits.push_back(1'($urandom_range(0, 1)));
        snap(); send(1, 0, 0);
        bus.rx_en = 1'b0;
        drive(LS_J, 6);
        expect_pkt("rx_en_abort", 1, 1, 1, 1, 0);
        tx_bits = {}; add_byte(8'hA5);
        snap(); send(1, 0, 1); drive(LS_J, 4);
        expect_pkt("rx_en_low_silent", 0, 0, 0, 0, 0);
        bus.rx_en = 1'b1;
        drive(LS_J, 20);

        // Reset mid-byte
        tx_bits = {}; add_byte(8'h5A);
        for (int i = 0; i < 4; i++) tx_bits.push_back(1'($urandom_range(0, 1)));
        send(1, 0, 0);
        drive(LS_J, 2);
        chk("pre-reset data", bus.data, 8'h5A);
        snap();
        reset_n = 1'b0;
        #1;
        chk_outputs_zero("mid reset");
        drive(LS_J, 2);
        reset_n = 1'b1;
        drive(LS_J, 40);
        chk("reset no pkt_end", n_end - s_end, 0);
        tx_bits = {}; add_byte(8'($urandom)); add_byte(8'($urandom));
        snap(); send(1, 0, 1); drive(LS_J, 4);
        expect_pkt("after_reset", 1, 2, 1, 0, 0);

        chk("pulse coincidence", n_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_fs_rx_line.md
# usb_fs_rx_line

Full-speed USB receive line decoder sitting directly downstream of the D+/D- line mux. It takes the mux's receive values `dp_rx`/`dn_rx`, sampled at 48 MHz (4x oversampling of 12 Mb/s), and performs:
- clock recovery
- NRZI decode
- sync detection
- bit unstuffing
- byte assembly
- EOP detection

It delivers a byte stream with packet framing and error flags to the packet-level receiver.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops on `dp_rx`/`dn_rx`; must be ≥2.
- `clk` in 1: 48 MHz clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx_en` in 1: receive enable; driven low by the top level while transmitting (`oe` high).
- `dp_rx` in 1: D+ receive value from the line mux.
- `dn_rx` in 1: D- receive value from the line mux.
- `pkt_start` out 1: one-clock pulse; sync pattern detected.
- `data` out 8: received byte, LSB first on wire; valid only while `data_valid` is high.
- `data_valid` out 1: one-clock pulse per assembled byte.
- `pkt_end` out 1: one-clock pulse; packet finished (EOP or abort).
- `stuff_err` out 1: one-clock pulse; seven consecutive 1s seen.
- `eop_err` out 1: one-clock pulse coincident with `pkt_end`; EOP or abort not on a byte boundary.

## Operation
- **Line state** (after synchronizer): J = (1,0), K = (0,1), SE0 = (0,0). SE1 = (1,1) is treated as the previous line state.
- **DPLL:**
  - 2-bit phase counter, free-running modulo 4.
  - Reset to 0 on any change of line state.
  - Bit sample strobe when phase == 2.
- **NRZI:** decoded bit = 1 if the sampled state equals the previous sampled state, else 0. Previous state resets to J.
- **State machine** IDLE, DATA, WAIT_EOP:
  - IDLE: 8-bit decoded-bit shift register. When the last 8 bits are seven 0s followed by a 1, pulse `pkt_start`, go to DATA, set ones-counter = 1, set bit-counter = 0. Sampled SE0 clears the shift register.
  - DATA, each strobe:
    - ones-counter == 6 and bit == 0: stuff bit; discard it and clear ones-counter.
    - ones-counter == 6 and bit == 1: pulse `stuff_err`, go to WAIT_EOP.
    - Otherwise: shift the bit into the byte (LSB first) and update ones-counter. On the 8th bit, present `data` with a `data_valid` pulse, then clear bit-counter.
  - DATA, EOP: ≥1 sampled SE0 followed by a sampled J. Pulse `pkt_end`, plus `eop_err` if bit-counter ≠ 0, then go to IDLE. The SE0 bit itself is not shifted.
  - WAIT_EOP: ignore bits. On SE0-then-J, pulse `pkt_end` (no `eop_err`) and go to IDLE.
- **`rx_en` low:**
  - In DATA or WAIT_EOP: pulse `pkt_end` with `eop_err` and go to IDLE.
  - While low: the block holds IDLE, all pulses stay 0, and the previous sampled state is forced to J.
- **Reset values:** all outputs 0, `data` = 0x00, state IDLE, counters 0.

## Timing
- Synchronizer latency is `SYNC_STAGES` clocks.
- All outputs are registered. Each pulse is asserted the clock after the sample strobe that caused it.
- `pkt_start` and `data_valid` never coincide.
- `data_valid` and `pkt_end` never coincide: EOP needs at least 2 strobes after the last data bit.
- `data` holds its value until the next `data_valid`.
- Jitter tolerance: bit periods of 3 or 5 clocks decode correctly because the phase counter realigns on every transition.
- `reset_n` is asynchronous assert with synchronous deassert at the top level. Mid-packet reset drops to IDLE with no `pkt_end`.

## Structure
- Shared package `usb_fs_pkg` holds:
  - line-state encodings J/K/SE0/SE1
  - the rx state enum IDLE/DATA/WAIT_EOP
  - sync pattern constant 8'b1000_0000 (shift-in order)
  - stuff limit constant 6
- Sub-module `usb_fs_rx_dpll` contains the synchronizer, line-state decode, phase counter, sample strobe and sampled line state. The top level contains NRZI decode, unstuffing, FSM and byte assembly.

## Test plan
- **Clean packet:** sync, bytes 0xA5 0x3C, EOP (SE0 2 bits, J) → one `pkt_start`; `data_valid` with 0xA5 then 0x3C; one `pkt_end`; both error flags 0.
- **Bit stuffing:** bytes 0xFF 0x00 with stuff bits inserted per USB rules → `data` 0xFF, 0x00; `stuff_err` 0.
- **Stuff violation:** seven consecutive 1s after sync → one `stuff_err`, no further `data_valid`; `pkt_end` without `eop_err` at the following EOP.
- **Misaligned EOP:** sync, 12 data bits, EOP → one `data_valid`; `pkt_end` and `eop_err` in the same clock.
- **Jitter:** 0xA5 with bit periods alternating 3/5 clocks → 0xA5 decoded, no errors.
- **Aborts and reset:**
  - `rx_en` dropped mid-byte → `pkt_end` with `eop_err`, then silence.
  - `reset_n` low mid-byte → all outputs 0 at once; next clean packet decodes correctly.
